// File: rtl/reg_file_wb_arb_if.sv
// Writeback bundle: two producer valid/ready channels in, register file write ports C/D
// and the pending-write scoreboard out.
interface reg_file_wb_arb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic                     p0_valid_in;
  logic                     p0_ready_out;
  logic [ADDR_W-1:0]        p0_addr_in;
  logic [DATA_W-1:0]        p0_data_in;
  logic                     p1_valid_in;
  logic                     p1_ready_out;
  logic [ADDR_W-1:0]        p1_addr_in;
  logic [DATA_W-1:0]        p1_data_in;
  logic                     r_c_wen_out;
  logic [ADDR_W-1:0]        r_c_waddr_out;
  logic [DATA_W-1:0]        c_out;
  logic                     r_d_wen_out;
  logic [ADDR_W-1:0]        r_d_waddr_out;
  logic [DATA_W-1:0]        d_out;
  logic [(1<<ADDR_W)-1:0]   pending_out;

  modport master (
    output p0_valid_in, p0_addr_in, p0_data_in,
    output p1_valid_in, p1_addr_in, p1_data_in,
    input  p0_ready_out, p1_ready_out,
    input  r_c_wen_out, r_c_waddr_out, c_out,
    input  r_d_wen_out, r_d_waddr_out, d_out,
    input  pending_out
  );

  modport slave (
    input  p0_valid_in, p0_addr_in, p0_data_in,
    input  p1_valid_in, p1_addr_in, p1_data_in,
    output p0_ready_out, p1_ready_out,
    output r_c_wen_out, r_c_waddr_out, c_out,
    output r_d_wen_out, r_d_waddr_out, d_out,
    output pending_out
  );
endinterface

// File: rtl/reg_file_wb_arb.sv
// Writeback arbiter: per-producer FIFOs feeding register file ports C/D, port C wins same-address collisions.
// Latency: 1 cycle accept->write (0 when REG_FILE_WB_ARB_BYPASS_EN bypasses an empty FIFO); collision adds 1 to port D.
// Backpressure: px_ready_out = FIFO not full, independent of same-cycle pop; low while reset_n is low.
module reg_file_wb_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  reg_file_wb_arb_if.slave wb
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo0_q [DEPTH];
  entry_t            fifo1_q [DEPTH];
  logic [PTR_W-1:0]  rd0_q, wr0_q, rd1_q, wr1_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;

  entry_t            in0, in1, head0, head1;
  logic              head0_vld, head1_vld;
  logic              byp0, byp1;
  logic              collide;
  logic              wen_c, wen_d;
  logic              ready0, ready1;
  logic              push0, push1, pop0, pop1;
  logic [NREG-1:0]   pend;
  logic [PTR_W-1:0]  off;

  assign in0    = '{addr: wb.p0_addr_in, data: wb.p0_data_in};
  assign in1    = '{addr: wb.p1_addr_in, data: wb.p1_data_in};
  assign ready0 = reset_n && (cnt0_q < CNT_W'(DEPTH));
  assign ready1 = reset_n && (cnt1_q < CNT_W'(DEPTH));

  always_comb begin
    head0     = fifo0_q[rd0_q];
    head1     = fifo1_q[rd1_q];
    head0_vld = (cnt0_q != '0);
    head1_vld = (cnt1_q != '0);
    byp0      = 1'b0;
    byp1      = 1'b0;
`ifdef REG_FILE_WB_ARB_BYPASS_EN
    if (reset_n && !head0_vld && wb.p0_valid_in) begin
      head0     = in0;
      head0_vld = 1'b1;
      byp0      = 1'b1;
    end
    if (reset_n && !head1_vld && wb.p1_valid_in) begin
      head1     = in1;
      head1_vld = 1'b1;
      byp1      = 1'b1;
    end
`endif
    // Port C always wins; port D retries the same head next cycle so its value lands last.
    collide = head0_vld && head1_vld && (head0.addr == head1.addr);
    wen_c   = head0_vld;
    wen_d   = head1_vld && !collide;
    pop0    = wen_c && !byp0;
    pop1    = wen_d && !byp1;
    // A bypassed p0 entry always issues; a bypassed p1 entry is stored only if it lost a collision.
    push0   = wb.p0_valid_in && ready0 && !byp0;
    push1   = wb.p1_valid_in && ready1 && !(byp1 && wen_d);
  end

  always_comb begin
    pend = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd0_q;
      if (CNT_W'(off) < cnt0_q) pend[fifo0_q[i].addr] = 1'b1;
      off = PTR_W'(i) - rd1_q;
      if (CNT_W'(off) < cnt1_q) pend[fifo1_q[i].addr] = 1'b1;
    end
    if (byp0) pend[head0.addr] = 1'b1;
    if (byp1) pend[head1.addr] = 1'b1;
  end

  // Storage needs no reset: only entries covered by a count are ever observed.
  always_ff @(posedge clock) begin
    if (push0) fifo0_q[wr0_q] <= in0;
    if (push1) fifo1_q[wr1_q] <= in1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd0_q  <= '0;
      wr0_q  <= '0;
      cnt0_q <= '0;
      rd1_q  <= '0;
      wr1_q  <= '0;
      cnt1_q <= '0;
    end else begin
      if (push0) wr0_q <= wr0_q + 1'b1;
      if (pop0)  rd0_q <= rd0_q + 1'b1;
      if (push1) wr1_q <= wr1_q + 1'b1;
      if (pop1)  rd1_q <= rd1_q + 1'b1;
      cnt0_q <= cnt0_q + CNT_W'(push0) - CNT_W'(pop0);
      cnt1_q <= cnt1_q + CNT_W'(push1) - CNT_W'(pop1);
    end
  end

  assign wb.p0_ready_out  = ready0;
  assign wb.p1_ready_out  = ready1;
  assign wb.r_c_wen_out   = wen_c;
  assign wb.r_c_waddr_out = wen_c ? head0.addr : '0;
  assign wb.c_out         = wen_c ? head0.data : '0;
  assign wb.r_d_wen_out   = wen_d;
  assign wb.r_d_waddr_out = wen_d ? head1.addr : '0;
  assign wb.d_out         = wen_d ? head1.data : '0;
  assign wb.pending_out   = pend;
endmodule

// File: tb/tb_reg_file_wb_arb.sv
// Bench for reg_file_wb_arb: directed scenarios plus random traffic against a queue-based reference.
module tb_reg_file_wb_arb;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;
  localparam int NREG   = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  reg_file_wb_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  reg_file_wb_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wb      (wb)
  );

  int checks = 0;
  int errors = 0;

  ent_t q0[$];
  ent_t q1[$];
  logic [DATA_W-1:0] rf_ref [NREG];
  logic [DATA_W-1:0] rf [NREG];
  logic acc0, acc1;

  // The register file downstream of the arbiter, written by the DUT's ports.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (wb.r_c_wen_out) rf[wb.r_c_waddr_out] <= wb.c_out;
      if (wb.r_d_wen_out) rf[wb.r_d_waddr_out] <= wb.d_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready0"}, wb.p0_ready_out, 0);
    chk({tag, "_ready1"}, wb.p1_ready_out, 0);
    chk({tag, "_wen_c"}, wb.r_c_wen_out, 0);
    chk({tag, "_addr_c"}, wb.r_c_waddr_out, 0);
    chk({tag, "_c_out"}, wb.c_out, 0);
    chk({tag, "_wen_d"}, wb.r_d_wen_out, 0);
    chk({tag, "_addr_d"}, wb.r_d_waddr_out, 0);
    chk({tag, "_d_out"}, wb.d_out, 0);
    chk({tag, "_pending"}, wb.pending_out, 0);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < NREG; i++) rf_ref[i] = '0;
  endtask

  // One clock cycle: called just after a rising edge with inputs already driven.
  task automatic cycle();
    logic ecw, edw, er0, er1;
    logic [ADDR_W-1:0] eca, eda;
    logic [DATA_W-1:0] ecd, edd;
    logic [NREG-1:0] epend;
    ent_t e;
    @(negedge clock);
    er0 = (q0.size() < DEPTH);
    er1 = (q1.size() < DEPTH);
    ecw = 0; eca = 0; ecd = 0;
    edw = 0; eda = 0; edd = 0;
    if (q0.size() > 0) begin
      ecw = 1; eca = q0[0].addr; ecd = q0[0].data;
    end
    if (q1.size() > 0) begin
      edw = 1;
      if (ecw && q0[0].addr == q1[0].addr) edw = 0;
      if (edw) begin eda = q1[0].addr; edd = q1[0].data; end
    end
    epend = '0;
    foreach (q0[i]) epend[q0[i].addr] = 1'b1;
    foreach (q1[i]) epend[q1[i].addr] = 1'b1;
    chk("ready0", wb.p0_ready_out, er0);
    chk("ready1", wb.p1_ready_out, er1);
    chk("wen_c", wb.r_c_wen_out, ecw);
    chk("addr_c", wb.r_c_waddr_out, eca);
    chk("c_out", wb.c_out, ecd);
    chk("wen_d", wb.r_d_wen_out, edw);
    chk("addr_d", wb.r_d_waddr_out, eda);
    chk("d_out", wb.d_out, edd);
    chk("pending", wb.pending_out, epend);
    if (ecw) begin rf_ref[eca] = ecd; void'(q0.pop_front()); end
    if (edw) begin rf_ref[eda] = edd; void'(q1.pop_front()); end
    acc0 = wb.p0_valid_in && er0;
    acc1 = wb.p1_valid_in && er1;
    if (acc0) begin e.addr = wb.p0_addr_in; e.data = wb.p0_data_in; q0.push_back(e); end
    if (acc1) begin e.addr = wb.p1_addr_in; e.data = wb.p1_data_in; q1.push_back(e); end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    wb.p0_valid_in = v0; wb.p0_addr_in = a0; wb.p0_data_in = d0;
    wb.p1_valid_in = v1; wb.p1_addr_in = a1; wb.p1_data_in = d1;
  endtask

  initial begin
    logic [DATA_W-1:0] seq0, seq1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    acc0 = 0;
    acc1 = 0;
    repeat (2) @(posedge clock);
    #2;
    chk_idle_outputs("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("ready0_after_release", wb.p0_ready_out, 1);
    chk("ready1_after_release", wb.p1_ready_out, 1);

`ifdef REG_FILE_WB_ARB_BYPASS_EN
    drive(1, 3'd7, 16'h00A5, 0, 0, 0);
    #1;
    chk("byp_wen_c", wb.r_c_wen_out, 1);
    chk("byp_addr_c", wb.r_c_waddr_out, 7);
    chk("byp_c_out", wb.c_out, 16'h00A5);
    chk("byp_pending", wb.pending_out, 8'h80);
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("byp_not_stored_wen_c", wb.r_c_wen_out, 0);
    chk("byp_not_stored_pending", wb.pending_out, 0);
    chk("byp_rf7", rf[7], 16'h00A5);
`else
    // Single write: accepted at edge 1, written during cycle 2.
    drive(1, 3'd3, 16'hBEEF, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_wen_c", wb.r_c_wen_out, 1);
    chk("t1_addr_c", wb.r_c_waddr_out, 3);
    chk("t1_c_out", wb.c_out, 16'hBEEF);
    chk("t1_pending", wb.pending_out, 8'h08);
    cycle();
    chk("t1_pending_clear", wb.pending_out, 0);
    chk("t1_wen_c_clear", wb.r_c_wen_out, 0);

    // Same-address collision: C first, D one cycle later.
    drive(1, 3'd5, 16'h1111, 1, 3'd5, 16'h2222);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    chk("col_wen_c", wb.r_c_wen_out, 1);
    chk("col_c_out", wb.c_out, 16'h1111);
    chk("col_wen_d_held", wb.r_d_wen_out, 0);
    cycle();
    chk("col_wen_d", wb.r_d_wen_out, 1);
    chk("col_addr_d", wb.r_d_waddr_out, 5);
    chk("col_d_out", wb.d_out, 16'h2222);
    cycle();
    chk("col_rf5", rf[5], 16'h2222);

    // Port D starved by repeated collisions while p1 keeps pushing.
    seq0 = 16'h0100;
    seq1 = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      drive(1, 3'd2, seq0, 1, 3'd2, seq1);
      cycle();
      if (acc0) seq0++;
      if (acc1) seq1++;
    end
    chk("starve_ready1_low", wb.p1_ready_out, 0);
    drive(0, 0, 0, 1, 3'd2, seq1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (acc1) begin seq1++; wb.p1_data_in = seq1; end
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // Random traffic, producers hold valid/data until accepted; pointers wrap many times.
    for (int i = 0; i < 400; i++) begin
      if (!wb.p0_valid_in || acc0) begin
        wb.p0_valid_in = ($urandom_range(0, 3) != 0);
        wb.p0_addr_in  = ADDR_W'($urandom_range(0, 3));
        wb.p0_data_in  = DATA_W'($urandom);
      end
      if (!wb.p1_valid_in || acc1) begin
        wb.p1_valid_in = ($urandom_range(0, 3) != 0);
        wb.p1_addr_in  = ADDR_W'($urandom_range(0, 3));
        wb.p1_data_in  = DATA_W'($urandom);
      end
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    for (int i = 0; i < NREG; i++) chk($sformatf("rf%0d", i), rf[i], rf_ref[i]);

    // Reset mid-operation with entries buffered.
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd1, 16'hA000 + 16'(i), 1, 3'd1, 16'hB000 + 16'(i));
      cycle();
    end
    chk("pre_reset_pending", wb.pending_out, 8'h02);
    #2;
    reset_n = 1'b0;
    #1;
    drive(0, 0, 0, 0, 0, 0);
    chk_idle_outputs("mid_reset");
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("ready0_after_mid_reset", wb.p0_ready_out, 1);
    chk("ready1_after_mid_reset", wb.p1_ready_out, 1);
    repeat (4) cycle();
    chk("no_stale_rf1", rf[1], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
